// File: rtl/energy_monitor_pkg.sv
// ============================================================================
// energy_monitor_pkg : shared types and sizing helpers for the energy stages
// Revision: 1.0
// ============================================================================
`default_nettype none

package energy_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  // Wide enough that DATAWIDTH entries of magnitude 2^(BITJ-1) sum without overflow.
  function automatic int dot_width(input int dw, input int bj);
    return bj + $clog2(dw) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spin_row_dot.sv
// ============================================================================
// spin_row_dot : combinational signed dot product of one coupling row with a
// +/-1 spin vector. Revision: 1.0
// ============================================================================
`default_nettype none

module spin_row_dot
  import energy_monitor_pkg::*;
#(
  parameter int DATAWIDTH = 256,
  parameter int BITJ      = 4
) (
  input  logic [DATAWIDTH-1:0]      spin_i,
  input  logic [DATAWIDTH*BITJ-1:0] weight_i,
  output logic [dot_width(DATAWIDTH, BITJ)-1:0] dot_o
);

  localparam int DOT_W = dot_width(DATAWIDTH, BITJ);

  logic signed [DOT_W-1:0] sum_w;
  logic signed [DOT_W-1:0] ent_w;

  // Entries are widened before negation so the most negative code negates exactly.
  always_comb begin
    sum_w = '0;
    ent_w = '0;
    for (int j = 0; j < DATAWIDTH; j++) begin
      ent_w = DOT_W'($signed(weight_i[j*BITJ +: BITJ]));
      if (spin_i[j] == SPIN_POS) begin
        sum_w = sum_w + ent_w;
      end else begin
        sum_w = sum_w - ent_w;
      end
    end
  end

  assign dot_o = sum_w;

endmodule

`default_nettype wire

// File: rtl/energy_row_accumulator.sv
// ============================================================================
// energy_row_accumulator : streams coupling rows and accumulates the Ising
// energy of the held spin vector. Revision: 1.0
// ============================================================================
`default_nettype none

module energy_row_accumulator
  import energy_monitor_pkg::*;
#(
  parameter int DATAWIDTH    = 256,
  parameter int BITJ         = 4,
  parameter int ENERGY_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      start_i,
  input  logic [DATAWIDTH-1:0]      spin_i,
  input  logic                      weight_valid_i,
  output logic                      weight_ready_o,
  input  logic [DATAWIDTH*BITJ-1:0] weight_i,
  output logic                      energy_valid_o,
  input  logic                      energy_ready_i,
  output logic [ENERGY_WIDTH-1:0]   energy_o,
  output logic                      busy_o
);

  localparam int DOT_W = dot_width(DATAWIDTH, BITJ);
  localparam int CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DATAWIDTH - 1);

  generate
    if (ENERGY_WIDTH < BITJ + 2 * $clog2(DATAWIDTH) + 1) begin : g_width_check
      $error("ENERGY_WIDTH too narrow for DATAWIDTH and BITJ");
    end
  endgenerate

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ENERGY_WIDTH-1:0]  prod_q, prod_d;
  logic                     prod_vld_q, prod_vld_d;
  logic [ENERGY_WIDTH-1:0]  acc_q, acc_d;

  logic                     row_hs;
  logic [DOT_W-1:0]         dot;
  logic signed [ENERGY_WIDTH-1:0] dot_ext;
  logic [ENERGY_WIDTH-1:0]  term;

  spin_row_dot #(
    .DATAWIDTH (DATAWIDTH),
    .BITJ      (BITJ)
  ) u_dot (
    .spin_i   (spin_i),
    .weight_i (weight_i),
    .dot_o    (dot)
  );

  assign row_hs  = weight_valid_i & weight_ready_o;
  assign dot_ext = ENERGY_WIDTH'($signed(dot));
  assign term    = (spin_i[cnt_q] == SPIN_POS) ? dot_ext : -dot_ext;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && en_i) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (row_hs && (cnt_q == LAST_ROW)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (energy_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; ready drops with en_i so an aborting row is never accepted
  always_comb begin
    weight_ready_o = en_i && (state_q == ST_ACCUM);
    energy_valid_o = (state_q == ST_DONE);
    busy_o         = (state_q != ST_IDLE);
    energy_o       = (state_q == ST_DONE) ? acc_q : '0;
  end

  // Datapath next values: one product stage, accumulated on the following edge
  always_comb begin
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    prod_vld_d = row_hs;
    acc_d      = acc_q;
    if (prod_vld_q) begin
      acc_d = acc_q + prod_q;
    end
    if (row_hs) begin
      prod_d = term;
      cnt_d  = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
    end
    if ((state_q == ST_IDLE) && start_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      cnt_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_energy_row_accumulator.sv
// ============================================================================
// tb_energy_row_accumulator : randomized and directed checks of the energy
// accumulator against a direct double-sum energy model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_energy_row_accumulator;

  localparam int N  = 4;
  localparam int BJ = 4;
  localparam int EW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          start_i;
  logic [N-1:0]  spin_i;
  logic          weight_valid_i;
  logic          weight_ready_o;
  logic [N*BJ-1:0] weight_i;
  logic          energy_valid_o;
  logic          energy_ready_i;
  logic [EW-1:0] energy_o;
  logic          busy_o;

  energy_row_accumulator #(
    .DATAWIDTH    (N),
    .BITJ         (BJ),
    .ENERGY_WIDTH (EW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .start_i        (start_i),
    .spin_i         (spin_i),
    .weight_valid_i (weight_valid_i),
    .weight_ready_o (weight_ready_o),
    .weight_i       (weight_i),
    .energy_valid_o (energy_valid_o),
    .energy_ready_i (energy_ready_i),
    .energy_o       (energy_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int J [N][N];
  logic [N*BJ-1:0] rows [N];
  int start_at_row = -1;

  // Energy straight from its definition: sum_i sum_j s_i * J_ij * s_j
  function automatic int ref_energy(input logic [N-1:0] s);
    int e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        e += (s[i] ? 1 : -1) * J[i][j] * (s[j] ? 1 : -1);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_rows();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rows[i][j*BJ +: BJ] = 4'(J[i][j]);
  endtask

  task automatic fill_J(input int mode, input int v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (mode)
          0: J[i][j] = v;
          1: J[i][j] = (i == j) ? 1 : 0;
          default: J[i][j] = int'($urandom_range(15)) - 8;
        endcase
    load_rows();
  endtask

  task automatic start_job();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_rows(input bit gappy, output bit to);
    int  i = 0;
    int  budget = 0;
    bit  tog = 1'b0;
    bit  hs;
    while (i < N && budget < 100) begin
      weight_valid_i = gappy ? tog : 1'b1;
      tog = ~tog;
      weight_i = rows[i];
      start_i  = (i == start_at_row);
      hs = weight_valid_i && weight_ready_o;
      tick();
      budget++;
      if (hs) i++;
    end
    weight_valid_i = 1'b0;
    start_i = 1'b0;
    to = (i < N);
  endtask

  task automatic wait_done(output bit to);
    int budget = 0;
    while (!energy_valid_o && budget < 20) begin
      tick();
      budget++;
    end
    to = !energy_valid_o;
  endtask

  task automatic ack();
    energy_ready_i = 1'b1;
    tick();
    energy_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if (energy_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", energy_valid_o); else n_pass++;
    n_checks++; if (energy_o !== 16'd0) $display("FAIL reset_energy: got %0h expected 0", energy_o); else n_pass++;
    n_checks++; if (weight_ready_o !== 1'b0) $display("FAIL reset_wready: got %b expected 0", weight_ready_o); else n_pass++;
  endtask

  task automatic test_basic_latency();
    bit to;
    spin_i = 4'b1111;
    fill_J(0, 1);
    start_job();
    n_checks++; if (busy_o !== 1'b1) $display("FAIL basic_busy_after_start: got %b expected 1", busy_o); else n_pass++;
    send_rows(1'b0, to);
    n_checks++; if (to) $display("FAIL basic_rows_timeout: got timeout expected rows accepted"); else n_pass++;
    n_checks++; if (energy_valid_o !== 1'b0 || weight_ready_o !== 1'b0)
      $display("FAIL basic_drain: got valid=%b ready=%b expected 0,0", energy_valid_o, weight_ready_o); else n_pass++;
    tick();
    n_checks++; if (energy_valid_o !== 1'b1) $display("FAIL basic_latency: got valid=%b expected 1 two cycles after last row", energy_valid_o); else n_pass++;
    n_checks++; if ($signed(energy_o) !== 16'(ref_energy(spin_i)) || energy_o !== 16'd16)
      $display("FAIL basic_energy: got %0d expected 16", $signed(energy_o)); else n_pass++;
    ack();
    n_checks++; if (energy_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL basic_ack: got valid=%b busy=%b expected 0,0", energy_valid_o, busy_o); else n_pass++;
  endtask

  task automatic test_negation();
    bit to;
    spin_i = 4'b0001;
    fill_J(0, -8);
    start_job();
    send_rows(1'b0, to);
    wait_done(to);
    n_checks++; if (to) $display("FAIL neg_timeout: got no valid expected valid"); else n_pass++;
    n_checks++; if (energy_o !== 16'hFFE0 || $signed(energy_o) !== 16'(ref_energy(spin_i)))
      $display("FAIL neg_energy: got %0h expected ffe0", energy_o); else n_pass++;
    ack();
  endtask

  task automatic test_backpressure();
    bit to;
    spin_i = 4'b1111;
    fill_J(0, 1);
    n_checks++; if (weight_ready_o !== 1'b0) $display("FAIL bp_idle_ready: got %b expected 0", weight_ready_o); else n_pass++;
    start_job();
    send_rows(1'b1, to);
    n_checks++; if (to || weight_ready_o !== 1'b0)
      $display("FAIL bp_drain_ready: got timeout=%b ready=%b expected 0,0", to, weight_ready_o); else n_pass++;
    wait_done(to);
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (to || energy_o !== 16'd16 || energy_valid_o !== 1'b1 || weight_ready_o !== 1'b0)
        $display("FAIL bp_hold[%0d]: got energy=%0d valid=%b ready=%b expected 16,1,0", k, $signed(energy_o), energy_valid_o, weight_ready_o);
      else n_pass++;
      tick();
    end
    ack();
    n_checks++; if (busy_o !== 1'b0 || energy_valid_o !== 1'b0 || energy_o !== 16'd0)
      $display("FAIL bp_idle_after_ack: got busy=%b valid=%b energy=%0d expected 0,0,0", busy_o, energy_valid_o, energy_o); else n_pass++;
  endtask

  task automatic test_ignored_start();
    bit to;
    spin_i = 4'b1010;
    fill_J(1, 0);
    start_job();
    start_at_row = 1;
    send_rows(1'b0, to);
    start_at_row = -1;
    wait_done(to);
    n_checks++; if (to || energy_o !== 16'd4 || $signed(energy_o) !== 16'(ref_energy(spin_i)))
      $display("FAIL ign_energy: got %0d expected 4", $signed(energy_o)); else n_pass++;
    start_i = 1'b1;
    ack();
    start_i = 1'b0;
    tick();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL ign_no_restart: got busy=%b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_abort();
    bit to;
    spin_i = 4'b1111;
    fill_J(0, 1);
    start_job();
    weight_valid_i = 1'b1;
    weight_i = rows[0];
    tick();
    weight_i = rows[1];
    tick();
    weight_i = rows[2];
    en_i = 1'b0;
    #1;
    n_checks++; if (weight_ready_o !== 1'b0) $display("FAIL abort_ready_comb: got %b expected 0", weight_ready_o); else n_pass++;
    tick();
    weight_valid_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || energy_o !== 16'd0 || energy_valid_o !== 1'b0)
      $display("FAIL abort_idle: got busy=%b energy=%0d valid=%b expected 0,0,0", busy_o, energy_o, energy_valid_o); else n_pass++;
    en_i = 1'b1;
    tick();
    start_job();
    send_rows(1'b0, to);
    wait_done(to);
    n_checks++; if (to || energy_o !== 16'd16) $display("FAIL abort_rerun: got %0d expected 16", $signed(energy_o)); else n_pass++;
    ack();
  endtask

  task automatic test_reset_in_done();
    bit to;
    logic [EW-1:0] want;
    spin_i = 4'b0110;
    fill_J(2, 0);
    start_job();
    send_rows(1'b0, to);
    wait_done(to);
    rst_ni = 1'b0;
    #1;
    n_checks++; if (to || energy_valid_o !== 1'b1) $display("FAIL rst_hold_valid: got %b expected 1 before edge", energy_valid_o); else n_pass++;
    tick();
    n_checks++; if (energy_valid_o !== 1'b0 || busy_o !== 1'b0 || energy_o !== 16'd0)
      $display("FAIL rst_clear: got valid=%b busy=%b energy=%0d expected 0,0,0", energy_valid_o, busy_o, energy_o); else n_pass++;
    rst_ni = 1'b1;
    spin_i = 4'($urandom_range(15));
    fill_J(2, 0);
    want = 16'(ref_energy(spin_i));
    start_job();
    send_rows(1'b1, to);
    wait_done(to);
    n_checks++; if (to || energy_o !== want) $display("FAIL rst_rerun: got %0d expected %0d", $signed(energy_o), $signed(want)); else n_pass++;
    ack();
  endtask

  task automatic test_random();
    bit to;
    logic [EW-1:0] want;
    int dly;
    for (int it = 0; it < 16; it++) begin
      spin_i = 4'($urandom_range(15));
      fill_J(2, 0);
      want = 16'(ref_energy(spin_i));
      start_job();
      send_rows(1'($urandom_range(1)), to);
      wait_done(to);
      dly = int'($urandom_range(3));
      repeat (dly) tick();
      n_checks++; if (to || energy_o !== want)
        $display("FAIL rand_energy[%0d]: got %0d expected %0d (spin=%b)", it, $signed(energy_o), $signed(want), spin_i);
      else n_pass++;
      ack();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i = 1'b1;
    start_i = 1'b0;
    spin_i = '0;
    weight_valid_i = 1'b0;
    weight_i = '0;
    energy_ready_i = 1'b0;
    tick();
    tick();
    test_reset();
    rst_ni = 1'b1;
    tick();
    test_basic_latency();
    test_negation();
    test_backpressure();
    test_ignored_start();
    test_abort();
    test_reset_in_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
